meta_fwd_ctrl: RTL and testbench

- Consumer end of the action-stage metadata path: accepts final per-packet comp_meta_data and applies it to the matching packet on the output AXI-Stream.
- Reads three fields from the metadata:
  - discard flag at bit [128];
  - dst_port at [31:24];
  - next_table_id at [355:350].
- Drops packets whose discard flag is set. Forwards all other packets with the first-beat tuser rewritten from metadata [127:0].
- Sits between the last RMT stage and the output queues.

---
 rtl/meta_fwd_ctrl.sv | 139 +++++++++++++
 tb/tb_meta_fwd_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/meta_fwd_ctrl.sv
// rtl/meta_fwd_ctrl.sv - metadata FIFO plus packet forward/drop controller at the RMT output
// Each popped metadata entry governs exactly one packet: drop it, or forward it with tuser rewritten on beat 0.
module meta_fwd_ctrl #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int META_LEN           = 256,
    parameter int COMP_LEN           = 100,
    parameter int MD_FIFO_AW         = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [META_LEN+COMP_LEN-1:0]      comp_meta_data_in,
    input  logic                              comp_meta_data_valid_in,
    output logic                              comp_meta_data_ready_out,
    input  logic [C_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    output logic [31:0]                       fwd_pkt_cnt,
    output logic [31:0]                       drop_pkt_cnt,
    output logic [5:0]                        last_table_id
);
    localparam int MD_W  = META_LEN + COMP_LEN;
    localparam int TU_W  = C_AXIS_TUSER_WIDTH;
    localparam int ENT_W = 6 + 1 + TU_W;
    localparam int DEPTH = 1 << MD_FIFO_AW;

    typedef enum logic [1:0] {WAIT_MD, FWD, DROP} state_t;

    // Only next_table_id, discard and the tuser image are stored; the rest of the metadata is not needed here.
    logic [ENT_W-1:0]      mem_q [DEPTH];
    logic [MD_FIFO_AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    state_t                state_q, state_d;
    logic                  first_q, first_d;
    logic [TU_W-1:0]       md_user_q, md_user_d;
    logic [31:0]           fwd_cnt_q, fwd_cnt_d, drop_cnt_q, drop_cnt_d;
    logic [5:0]            tid_q, tid_d;

    logic                  full, empty, push;
    logic [ENT_W-1:0]      head, wr_entry;
    logic                  unused_md_bits;

    assign full  = (wr_ptr_q[MD_FIFO_AW] != rd_ptr_q[MD_FIFO_AW]) &&
                   (wr_ptr_q[MD_FIFO_AW-1:0] == rd_ptr_q[MD_FIFO_AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign comp_meta_data_ready_out = !rst && !full;
    assign push  = comp_meta_data_valid_in && comp_meta_data_ready_out;

    assign wr_entry = {comp_meta_data_in[MD_W-1 -: 6], comp_meta_data_in[TU_W], comp_meta_data_in[TU_W-1:0]};
    assign head     = mem_q[rd_ptr_q[MD_FIFO_AW-1:0]];
    assign unused_md_bits = ^comp_meta_data_in[MD_W-7:TU_W+1];

    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tkeep  = s_axis_tkeep;
    assign m_axis_tlast  = s_axis_tlast;
    assign m_axis_tuser  = first_q ? md_user_q : s_axis_tuser;
    assign fwd_pkt_cnt   = fwd_cnt_q;
    assign drop_pkt_cnt  = drop_cnt_q;
    assign last_table_id = tid_q;

    always_comb begin
        state_d       = state_q;
        first_d       = first_q;
        md_user_d     = md_user_q;
        fwd_cnt_d     = fwd_cnt_q;
        drop_cnt_d    = drop_cnt_q;
        tid_d         = tid_q;
        wr_ptr_d      = wr_ptr_q + {{MD_FIFO_AW{1'b0}}, push};
        rd_ptr_d      = rd_ptr_q;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        case (state_q)
            WAIT_MD: begin
                if (!empty) begin
                    rd_ptr_d  = rd_ptr_q + 1'b1;
                    md_user_d = head[TU_W-1:0];
                    tid_d     = head[ENT_W-1 -: 6];
                    first_d   = 1'b1;
                    state_d   = head[TU_W] ? DROP : FWD;
                end
            end
            FWD: begin
                m_axis_tvalid = s_axis_tvalid;
                s_axis_tready = m_axis_tready;
                if (s_axis_tvalid && m_axis_tready) begin
                    first_d = 1'b0;
                    if (s_axis_tlast) begin
                        fwd_cnt_d = (fwd_cnt_q == 32'hFFFF_FFFF) ? fwd_cnt_q : fwd_cnt_q + 32'd1;
                        state_d   = WAIT_MD;
                    end
                end
            end
            DROP: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    drop_cnt_d = (drop_cnt_q == 32'hFFFF_FFFF) ? drop_cnt_q : drop_cnt_q + 32'd1;
                    state_d    = WAIT_MD;
                end
            end
            default: state_d = WAIT_MD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[MD_FIFO_AW-1:0]] <= wr_entry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= WAIT_MD;
            first_q    <= 1'b0;
            md_user_q  <= '0;
            fwd_cnt_q  <= '0;
            drop_cnt_q <= '0;
            tid_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            first_q    <= first_d;
            md_user_q  <= md_user_d;
            fwd_cnt_q  <= fwd_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            tid_q      <= tid_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end
endmodule

// File: tb/tb_meta_fwd_ctrl.sv
// tb/tb_meta_fwd_ctrl.sv - self-checking bench for meta_fwd_ctrl
module tb_meta_fwd_ctrl;
    logic         clk = 1'b0;
    logic         rst;
    logic [355:0] comp_meta_data_in;
    logic         comp_meta_data_valid_in;
    logic         comp_meta_data_ready_out;
    logic [255:0] s_axis_tdata;
    logic [31:0]  s_axis_tkeep;
    logic [127:0] s_axis_tuser;
    logic         s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tkeep;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic [31:0]  fwd_pkt_cnt, drop_pkt_cnt;
    logic [5:0]   last_table_id;

    int checks = 0;
    int errors = 0;
    int exp_fwd = 0;
    int exp_drop = 0;

    typedef struct {
        logic         disc;
        logic [127:0] user;
        logic [5:0]   tid;
        int           nbeats;
        int           exp_out;
        int           exp_cycles;
        int           exp_fwd;
        int           exp_drop;
    } vec_t;

    typedef struct {
        logic         disc;
        logic [127:0] user;
        logic [5:0]   tid;
    } md_t;

    vec_t tbl[5];
    md_t  mq[$];

    always #5 clk = ~clk;

    meta_fwd_ctrl dut (
        .clk(clk), .rst(rst),
        .comp_meta_data_in(comp_meta_data_in),
        .comp_meta_data_valid_in(comp_meta_data_valid_in),
        .comp_meta_data_ready_out(comp_meta_data_ready_out),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .fwd_pkt_cnt(fwd_pkt_cnt), .drop_pkt_cnt(drop_pkt_cnt), .last_table_id(last_table_id)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] beat_data(input int tag, input int b);
        return {8{32'(tag * 256 + b)}};
    endfunction

    function automatic logic [127:0] beat_user(input int b);
        return {96'h0, 32'h5500_0000 + 32'(b)};
    endfunction

    function automatic logic [31:0] beat_keep(input int b);
        return 32'hFFFF_FFFF >> (b % 4);
    endfunction

    function automatic logic [127:0] ful_user(input int i);
        return {96'h0, 8'(i), 24'h00F00D};
    endfunction

    // Random filler everywhere, then the three fields the block consumes.
    function automatic logic [355:0] mk_md(input logic disc, input logic [127:0] user, input logic [5:0] tid);
        logic [355:0] v;
        for (int k = 0; k < 356; k++) v[k] = 1'($urandom_range(0, 1));
        v[127:0]   = user;
        v[128]     = disc;
        v[355:350] = tid;
        return v;
    endfunction

    task automatic push_md(input logic disc, input logic [127:0] user, input logic [5:0] tid);
        int n;
        n = 0;
        comp_meta_data_in = mk_md(disc, user, tid);
        comp_meta_data_valid_in = 1'b1;
        while (!comp_meta_data_ready_out && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("push_timeout", 1'b1, 1'b0);
        tick();
        comp_meta_data_valid_in = 1'b0;
    endtask

    // mode 0: m_tready=1, mode 1: toggling, mode 2: random valid/ready.
    task automatic drive_pkt(input int tag, input int nbeats, input int mode, input logic drop,
                             input logic [127:0] md_user, output int cycles, output int got);
        int sent, cyc;
        logic [127:0] exp_user;
        sent = 0; got = 0; cyc = 0;
        while (sent < nbeats && cyc < 400) begin
            s_axis_tvalid = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_axis_tdata  = beat_data(tag, sent);
            s_axis_tuser  = beat_user(sent);
            s_axis_tkeep  = beat_keep(sent);
            s_axis_tlast  = (sent == nbeats - 1);
            m_axis_tready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (sent > 0 && s_axis_tvalid) chk("s_tready", s_axis_tready, drop ? 1'b1 : m_axis_tready);
            if (drop) chk("drop_no_mvalid", m_axis_tvalid, 1'b0);
            if (m_axis_tvalid && m_axis_tready) begin
                exp_user = (got == 0) ? md_user : beat_user(got);
                chk("tdata", m_axis_tdata, beat_data(tag, got));
                chk("tuser", m_axis_tuser, exp_user);
                chk("tkeep", m_axis_tkeep, beat_keep(got));
                chk("tlast", m_axis_tlast, got == nbeats - 1);
                got++;
            end
            if (s_axis_tvalid && s_axis_tready) sent++;
            tick();
            cyc++;
        end
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        if (sent < nbeats) chk("pkt_timeout", 1'b1, 1'b0);
        cycles = cyc;
    endtask

    task automatic chk_counts(input string name);
        chk({name, "_fwd"}, fwd_pkt_cnt, 32'(exp_fwd));
        chk({name, "_drop"}, drop_pkt_cnt, 32'(exp_drop));
    endtask

    initial begin
        int cyc, got, sent, k, nb;
        md_t e;
        logic [5:0] last_tid;

        tbl[0] = '{disc: 1'b0, user: 128'hDEAD_BEEF_0000_0000_0000_0000_04AB_CDEF, tid: 6'h05,
                   nbeats: 3, exp_out: 3, exp_cycles: 4, exp_fwd: 1, exp_drop: 0};
        tbl[1] = '{disc: 1'b1, user: 128'h1234_0000_0000_0000_0000_0000_0900_0001, tid: 6'h09,
                   nbeats: 4, exp_out: 0, exp_cycles: 5, exp_fwd: 1, exp_drop: 1};
        tbl[2] = '{disc: 1'b0, user: 128'hCAFE_0000_0000_0000_0000_0000_0A00_0002, tid: 6'h3F,
                   nbeats: 1, exp_out: 1, exp_cycles: 2, exp_fwd: 2, exp_drop: 1};
        tbl[3] = '{disc: 1'b1, user: 128'h0, tid: 6'h00,
                   nbeats: 1, exp_out: 0, exp_cycles: 2, exp_fwd: 2, exp_drop: 2};
        tbl[4] = '{disc: 1'b0, user: 128'hFFFF_FFFF_0000_1111_2222_3333_0C44_5555, tid: 6'h2A,
                   nbeats: 5, exp_out: 5, exp_cycles: 6, exp_fwd: 3, exp_drop: 2};

        rst = 1'b1;
        comp_meta_data_in = '0; comp_meta_data_valid_in = 1'b0;
        s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser = '0;
        s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_axis_tready = 1'b1;
        repeat (3) tick();
        chk("rst_ready", comp_meta_data_ready_out, 1'b0);
        chk("rst_s_tready", s_axis_tready, 1'b0);
        chk("rst_m_tvalid", m_axis_tvalid, 1'b0);
        chk_counts("rst");
        chk("rst_tid", last_table_id, 6'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", comp_meta_data_ready_out, 1'b1);

        for (int i = 0; i < 5; i++) begin
            push_md(tbl[i].disc, tbl[i].user, tbl[i].tid);
            drive_pkt(i + 1, tbl[i].nbeats, 0, tbl[i].disc, tbl[i].user, cyc, got);
            chk("tbl_beats", got, tbl[i].exp_out);
            chk("tbl_cycles", cyc, tbl[i].exp_cycles);
            exp_fwd = tbl[i].exp_fwd;
            exp_drop = tbl[i].exp_drop;
            chk_counts("tbl");
            chk("tbl_tid", last_table_id, tbl[i].tid);
        end

        // Packet waits with no metadata available.
        s_axis_tvalid = 1'b1; s_axis_tdata = beat_data(50, 0); s_axis_tuser = beat_user(0);
        s_axis_tkeep = beat_keep(0); s_axis_tlast = 1'b0; m_axis_tready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall", {s_axis_tready, m_axis_tvalid}, 2'b00);
            tick();
        end
        push_md(1'b0, 128'h0000_0000_0000_0000_0000_0000_0707_0707, 6'h07);
        drive_pkt(50, 3, 0, 1'b0, 128'h0000_0000_0000_0000_0000_0000_0707_0707, cyc, got);
        chk("stall_beats", got, 3);
        exp_fwd++;

        push_md(1'b0, 128'hABCD_0000_0000_0000_0000_0000_1100_0000, 6'h11);
        drive_pkt(55, 6, 1, 1'b0, 128'hABCD_0000_0000_0000_0000_0000_1100_0000, cyc, got);
        chk("toggle_beats", got, 6);
        exp_fwd++;
        chk_counts("toggle");

        // Fill: one entry is popped straight into the FSM, so nine pushes fill eight slots.
        for (int i = 0; i < 9; i++) begin
            push_md(1'(i % 2), ful_user(i), 6'(i));
            if (i == 7) chk("ready_not_full", comp_meta_data_ready_out, 1'b1);
        end
        chk("ready_full", comp_meta_data_ready_out, 1'b0);
        comp_meta_data_in = mk_md(1'b1, ful_user(9), 6'd9);
        comp_meta_data_valid_in = 1'b1;
        drive_pkt(60, 1, 0, 1'b0, ful_user(0), cyc, got);
        chk("full_pkt0", got, 1);
        exp_fwd++;
        chk("ready_pop_cycle", comp_meta_data_ready_out, 1'b0);
        chk("tid_pre_pop", last_table_id, 6'd0);
        tick();
        chk("ready_after_pop", comp_meta_data_ready_out, 1'b1);
        chk("tid_post_pop", last_table_id, 6'd1);
        tick();
        chk("ready_refull", comp_meta_data_ready_out, 1'b0);
        comp_meta_data_valid_in = 1'b0;
        for (int i = 1; i < 10; i++) begin
            drive_pkt(60 + i, 2, 0, 1'(i % 2), ful_user(i), cyc, got);
            chk("order_beats", got, (i % 2) ? 0 : 2);
            if (i % 2) exp_drop++; else exp_fwd++;
        end
        chk_counts("order");
        chk("order_tid", last_table_id, 6'd9);

        // Randomized batches against a queue model of metadata order.
        for (int b = 0; b < 8; b++) begin
            k = $urandom_range(1, 4);
            for (int j = 0; j < k; j++) begin
                e.disc = 1'($urandom_range(0, 1));
                e.user = {$urandom(), $urandom(), $urandom(), $urandom()};
                e.tid  = 6'($urandom_range(0, 63));
                mq.push_back(e);
                repeat ($urandom_range(0, 2)) tick();
                push_md(e.disc, e.user, e.tid);
            end
            last_tid = 6'h0;
            while (mq.size() > 0) begin
                e = mq.pop_front();
                last_tid = e.tid;
                nb = $urandom_range(1, 6);
                drive_pkt(100 + b * 8 + mq.size(), nb, 2, e.disc, e.user, cyc, got);
                chk("rand_beats", got, e.disc ? 0 : nb);
                if (e.disc) exp_drop++; else exp_fwd++;
            end
            chk_counts("rand");
            chk("rand_tid", last_table_id, last_tid);
        end

        // Reset in the middle of a forwarded packet with two entries still queued.
        for (int i = 0; i < 3; i++) push_md(1'b0, ful_user(20 + i), 6'(10 + i));
        sent = 0;
        s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0; m_axis_tready = 1'b1;
        for (int c = 0; c < 20 && sent < 2; c++) begin
            s_axis_tdata = beat_data(80, sent); s_axis_tuser = beat_user(sent);
            @(negedge clk);
            if (s_axis_tvalid && s_axis_tready) sent++;
            tick();
        end
        chk("pre_rst_beats", sent, 2);
        chk("pre_rst_mvalid", m_axis_tvalid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_mvalid", m_axis_tvalid, 1'b0);
        chk("midrst_ready", comp_meta_data_ready_out, 1'b0);
        exp_fwd = 0;
        exp_drop = 0;
        chk_counts("midrst");
        chk("midrst_tid", last_table_id, 6'h0);
        @(negedge clk);
        rst = 1'b0;
        s_axis_tvalid = 1'b0;
        tick();
        chk("postrst_ready", comp_meta_data_ready_out, 1'b1);
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("postrst_empty", s_axis_tready, 1'b0);
            tick();
        end
        s_axis_tvalid = 1'b0;
        push_md(1'b1, ful_user(33), 6'h21);
        drive_pkt(90, 2, 0, 1'b1, ful_user(33), cyc, got);
        chk("recover_beats", got, 0);
        exp_drop++;
        chk_counts("recover");
        chk("recover_tid", last_table_id, 6'h21);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
